// File: rtl/ddr4_cmd_timing_checker_if.sv
// DDR4 command-timing checker bus: decoded command stream, timing limits,
// bank state and violation report.
interface ddr4_cmd_timing_checker_if #(
  parameter int BG_W   = 2,
  parameter int BA_W   = 2,
  parameter int CNT_W  = 8,
  parameter int VCNT_W = 16
);
  logic                          cmd_valid;
  logic [2:0]                    cmd_type;
  logic [BG_W-1:0]               cmd_bg;
  logic [BA_W-1:0]               cmd_ba;
  logic [CNT_W-1:0]              cfg_trcd;
  logic [CNT_W-1:0]              cfg_trp;
  logic [CNT_W-1:0]              cfg_tras;
  logic [CNT_W-1:0]              cfg_tccd_s;
  logic [CNT_W-1:0]              cfg_tccd_l;
  logic [CNT_W-1:0]              cfg_trrd_s;
  logic [CNT_W-1:0]              cfg_trrd_l;
  logic [CNT_W-1:0]              cfg_tfaw;
  logic [2**(BG_W+BA_W)-1:0]     bank_open;
  logic                          viol_valid;
  logic [3:0]                    viol_code;
  logic [BG_W+BA_W-1:0]          viol_bank;
  logic [VCNT_W-1:0]             viol_count;

  modport master (
    output cmd_valid, cmd_type, cmd_bg, cmd_ba,
    output cfg_trcd, cfg_trp, cfg_tras,
    output cfg_tccd_s, cfg_tccd_l,
    output cfg_trrd_s, cfg_trrd_l, cfg_tfaw,
    input  bank_open, viol_valid, viol_code,
    input  viol_bank, viol_count
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_bg, cmd_ba,
    input  cfg_trcd, cfg_trp, cfg_tras,
    input  cfg_tccd_s, cfg_tccd_l,
    input  cfg_trrd_s, cfg_trrd_l, cfg_tfaw,
    output bank_open, viol_valid, viol_code,
    output viol_bank, viol_count
  );
endinterface

// File: rtl/ddr4_cmd_timing_checker.sv
// DDR4 command-timing monitor: per-bank open/closed state, tRCD/tRP/tRAS,
// tCCD_S/L, tRRD_S/L and tFAW checks with a registered violation report.
module ddr4_cmd_timing_checker #(
  parameter int BG_W   = 2,
  parameter int BA_W   = 2,
  parameter int CNT_W  = 8,
  parameter int FAW_N  = 4,
  parameter int VCNT_W = 16
) (
  input logic clk,
  input logic rst,
  ddr4_cmd_timing_checker_if.slave bus
);

  localparam int AW = BG_W + BA_W;
  localparam int NB = 2**AW;
  localparam int PW = (FAW_N > 1) ? $clog2(FAW_N) : 1;
  localparam int NW = $clog2(FAW_N + 1);

  typedef enum logic [2:0] {
    C_NOP, C_ACT, C_RD, C_WR,
    C_PRE, C_PREA, C_REF, C_RSV
  } cmd_e;

  logic [CNT_W-1:0]  act_cnt [NB];
  logic [CNT_W-1:0]  pre_cnt [NB];
  logic [CNT_W-1:0]  faw_cnt [FAW_N];
  logic [CNT_W-1:0]  last_act_cnt;
  logic [CNT_W-1:0]  last_cas_cnt;
  logic [BG_W-1:0]   last_act_bg;
  logic [BG_W-1:0]   last_cas_bg;
  logic [PW-1:0]     faw_ptr;
  logic [NW-1:0]     faw_num;
  logic [NB-1:0]     open_q;
  logic              viol_valid_q;
  logic [3:0]        viol_code_q;
  logic [AW-1:0]     viol_bank_q;
  logic [VCNT_W-1:0] viol_count_q;

  logic [AW-1:0]     addr;
  cmd_e              ctype;
  logic              is_act, is_cas, is_pre;
  logic              is_prea, is_ref, is_rsv;
  logic              faw_full;
  logic [CNT_W-1:0]  rrd_lim, ccd_lim;
  logic [NB-1:0]     tras_bad;
  logic [AW-1:0]     tras_idx, open_idx;
  logic [3:0]        code_c;
  logic [AW-1:0]     bank_c;

  // Saturating elapsed counters: all-ones means "long ago".
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  // elapsed+1 is the command spacing in clocks.
  function automatic logic too_soon(
    input logic [CNT_W-1:0] e,
    input logic [CNT_W-1:0] lim
  );
    return ({1'b0, e} + 1'b1) < {1'b0, lim};
  endfunction

  assign addr     = {bus.cmd_bg, bus.cmd_ba};
  assign ctype    = cmd_e'(bus.cmd_type);
  assign is_act   = bus.cmd_valid && (ctype == C_ACT);
  assign is_cas   = bus.cmd_valid &&
                    ((ctype == C_RD) || (ctype == C_WR));
  assign is_pre   = bus.cmd_valid && (ctype == C_PRE);
  assign is_prea  = bus.cmd_valid && (ctype == C_PREA);
  assign is_ref   = bus.cmd_valid && (ctype == C_REF);
  assign is_rsv   = bus.cmd_valid && (ctype == C_RSV);
  assign faw_full = (faw_num == NW'(FAW_N));
  assign rrd_lim  = (last_act_bg == bus.cmd_bg) ?
                    bus.cfg_trrd_l : bus.cfg_trrd_s;
  assign ccd_lim  = (last_cas_bg == bus.cmd_bg) ?
                    bus.cfg_tccd_l : bus.cfg_tccd_s;

  always_comb begin
    tras_bad = '0;
    tras_idx = '0;
    open_idx = '0;
    for (int i = 0; i < NB; i++)
      tras_bad[i] = open_q[i] &&
                    too_soon(act_cnt[i], bus.cfg_tras);
    for (int i = NB - 1; i >= 0; i--) begin
      if (tras_bad[i]) tras_idx = AW'(i);
      if (open_q[i])   open_idx = AW'(i);
    end
  end

  // Checks are ordered so the lowest code wins.
  always_comb begin
    code_c = 4'd0;
    bank_c = addr;
    unique case (1'b1)
      is_act: begin
        if (open_q[addr])
          code_c = 4'd1;
        else if (too_soon(pre_cnt[addr], bus.cfg_trp))
          code_c = 4'd2;
        else if (too_soon(last_act_cnt, rrd_lim))
          code_c = 4'd3;
        else if (faw_full &&
                 too_soon(faw_cnt[faw_ptr], bus.cfg_tfaw))
          code_c = 4'd4;
      end
      is_cas: begin
        if (!open_q[addr])
          code_c = 4'd5;
        else if (too_soon(act_cnt[addr], bus.cfg_trcd))
          code_c = 4'd6;
        else if (too_soon(last_cas_cnt, ccd_lim))
          code_c = 4'd7;
      end
      is_pre: begin
        if (tras_bad[addr]) code_c = 4'd8;
      end
      is_prea: begin
        if (|tras_bad) begin
          code_c = 4'd8;
          bank_c = tras_idx;
        end
      end
      is_ref: begin
        if (|open_q) begin
          code_c = 4'd9;
          bank_c = open_idx;
        end
      end
      is_rsv: code_c = 4'd15;
      default: code_c = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        act_cnt[i] <= '1;
        pre_cnt[i] <= '1;
      end
      for (int j = 0; j < FAW_N; j++)
        faw_cnt[j] <= '1;
      last_act_cnt <= '1;
      last_cas_cnt <= '1;
      last_act_bg  <= '0;
      last_cas_bg  <= '0;
      faw_ptr      <= '0;
      faw_num      <= '0;
      open_q       <= '0;
      viol_valid_q <= 1'b0;
      viol_code_q  <= '0;
      viol_bank_q  <= '0;
      viol_count_q <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        act_cnt[i] <= sat_inc(act_cnt[i]);
        pre_cnt[i] <= sat_inc(pre_cnt[i]);
      end
      for (int j = 0; j < FAW_N; j++)
        faw_cnt[j] <= sat_inc(faw_cnt[j]);
      last_act_cnt <= sat_inc(last_act_cnt);
      last_cas_cnt <= sat_inc(last_cas_cnt);

      viol_valid_q <= |code_c;
      viol_code_q  <= code_c;
      viol_bank_q  <= (|code_c) ? bank_c : '0;
      if ((|code_c) && !(&viol_count_q))
        viol_count_q <= viol_count_q + 1'b1;

      // State tracks issued commands, legal or not.
      if (is_act) begin
        open_q[addr]     <= 1'b1;
        act_cnt[addr]    <= '0;
        last_act_cnt     <= '0;
        last_act_bg      <= bus.cmd_bg;
        faw_cnt[faw_ptr] <= '0;
        faw_ptr <= (faw_ptr == PW'(FAW_N - 1)) ?
                   '0 : faw_ptr + 1'b1;
        if (!faw_full) faw_num <= faw_num + 1'b1;
      end
      if (is_cas) begin
        last_cas_cnt <= '0;
        last_cas_bg  <= bus.cmd_bg;
      end
      if (is_pre && open_q[addr]) begin
        open_q[addr]  <= 1'b0;
        pre_cnt[addr] <= '0;
      end
      if (is_prea) begin
        for (int i = 0; i < NB; i++)
          if (open_q[i]) begin
            open_q[i]  <= 1'b0;
            pre_cnt[i] <= '0;
          end
      end
    end
  end

  assign bus.bank_open  = open_q;
  assign bus.viol_valid = viol_valid_q;
  assign bus.viol_code  = viol_code_q;
  assign bus.viol_bank  = viol_bank_q;
  assign bus.viol_count = viol_count_q;

endmodule

// File: tb/tb_ddr4_cmd_timing_checker.sv
// Directed-vector bench for ddr4_cmd_timing_checker: table of commands with
// hand-computed reports plus reset and runtime-config sequences.
module tb_ddr4_cmd_timing_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ddr4_cmd_timing_checker_if #(
    .BG_W(2), .BA_W(2), .CNT_W(8), .VCNT_W(16)
  ) bus ();

  ddr4_cmd_timing_checker #(
    .BG_W(2), .BA_W(2), .CNT_W(8),
    .FAW_N(4), .VCNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        r;
    logic        v;
    logic [2:0]  t;
    logic [1:0]  bg;
    logic [1:0]  ba;
    int          w;
    logic        ev;
    logic [3:0]  ec;
    logic [3:0]  eb;
    logic [15:0] ecnt;
    logic [15:0] eopen;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic [2:0] t,
    input logic [1:0] bg, input logic [1:0] ba,
    input int w, input logic [3:0] ec,
    input logic [3:0] eb, input logic [15:0] ecnt,
    input logic [15:0] eopen
  );
    vec_t x;
    x.r = r; x.v = !r; x.t = t; x.bg = bg; x.ba = ba;
    x.w = w; x.ev = (ec != 4'd0); x.ec = ec; x.eb = eb;
    x.ecnt = ecnt; x.eopen = eopen;
    return x;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 3'd0;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic r, input logic v,
                       input logic [2:0] t,
                       input logic [1:0] bg,
                       input logic [1:0] ba);
    rst           = r;
    bus.cmd_valid = v;
    bus.cmd_type  = t;
    bus.cmd_bg    = bg;
    bus.cmd_ba    = ba;
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 3'd0;
  endtask

  task automatic chk_out(input string nm, input logic ev,
                         input logic [3:0] ec,
                         input logic [3:0] eb,
                         input logic [15:0] ecnt,
                         input logic [15:0] eopen);
    chk({nm, ".valid"}, 32'(bus.viol_valid), 32'(ev));
    chk({nm, ".code"},  32'(bus.viol_code),  32'(ec));
    chk({nm, ".bank"},  32'(bus.viol_bank),  32'(eb));
    chk({nm, ".count"}, 32'(bus.viol_count), 32'(ecnt));
    chk({nm, ".open"},  32'(bus.bank_open),  32'(eopen));
  endtask

  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2;
  localparam logic [2:0] WR = 3'd3, PRE = 3'd4, PREA = 3'd5;
  localparam logic [2:0] REF = 3'd6, RSV = 3'd7;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_type   = NOP;
    bus.cmd_bg     = '0;
    bus.cmd_ba     = '0;
    bus.cfg_trcd   = 8'd11;
    bus.cfg_trp    = 8'd11;
    bus.cfg_tras   = 8'd28;
    bus.cfg_tccd_s = 8'd4;
    bus.cfg_tccd_l = 8'd6;
    bus.cfg_trrd_s = 8'd4;
    bus.cfg_trrd_l = 8'd6;
    bus.cfg_tfaw   = 8'd20;

    //          r  type  bg ba wait code bank cnt open
    tbl.push_back(mk(1, NOP,  0, 0,  0,  0,  0,  0, 16'h0000));
    tbl.push_back(mk(0, ACT,  0, 0,  0,  0,  0,  0, 16'h0001));
    tbl.push_back(mk(0, RD,   0, 0,  9,  6,  0,  1, 16'h0001));
    tbl.push_back(mk(0, ACT,  1, 0,  0,  0,  0,  1, 16'h0011));
    tbl.push_back(mk(0, RD,   0, 0, 10,  0,  0,  1, 16'h0011));
    tbl.push_back(mk(0, RD,   1, 0,  3,  0,  0,  1, 16'h0011));
    tbl.push_back(mk(0, RD,   1, 0,  5,  0,  0,  1, 16'h0011));
    tbl.push_back(mk(0, WR,   1, 0,  4,  7,  4,  2, 16'h0011));
    tbl.push_back(mk(0, RD,   0, 0,  3,  0,  0,  2, 16'h0011));
    tbl.push_back(mk(0, RD,   0, 0,  2,  7,  0,  3, 16'h0011));
    tbl.push_back(mk(0, ACT,  1, 1,  0,  0,  0,  3, 16'h0031));
    tbl.push_back(mk(0, PRE,  1, 1,  9,  8,  5,  4, 16'h0011));
    tbl.push_back(mk(0, ACT,  1, 1,  4,  2,  5,  5, 16'h0031));
    tbl.push_back(mk(0, PRE,  0, 0, 30,  0,  0,  5, 16'h0030));
    tbl.push_back(mk(0, PRE,  0, 0,  0,  0,  0,  5, 16'h0030));
    tbl.push_back(mk(0, PREA, 0, 0,  0,  0,  0,  5, 16'h0000));
    tbl.push_back(mk(0, ACT,  0, 3,  0,  0,  0,  5, 16'h0008));
    tbl.push_back(mk(0, ACT,  2, 1,  3,  0,  0,  5, 16'h0208));
    tbl.push_back(mk(0, REF,  0, 0,  0,  9,  3,  6, 16'h0208));
    tbl.push_back(mk(0, RD,   3, 2,  0,  5, 14,  7, 16'h0208));
    tbl.push_back(mk(0, RSV,  1, 2,  0, 15,  6,  8, 16'h0208));
    tbl.push_back(mk(0, PREA, 0, 0,  0,  8,  3,  9, 16'h0000));
    tbl.push_back(mk(0, ACT,  0, 3,  0,  2,  3, 10, 16'h0008));
    tbl.push_back(mk(0, ACT,  0, 3,  0,  1,  3, 11, 16'h0008));
    tbl.push_back(mk(1, NOP,  0, 0,  0,  0,  0,  0, 16'h0000));
    tbl.push_back(mk(0, ACT,  0, 0,  0,  0,  0,  0, 16'h0001));
    tbl.push_back(mk(0, ACT,  1, 0,  3,  0,  0,  0, 16'h0011));
    tbl.push_back(mk(0, ACT,  2, 0,  3,  0,  0,  0, 16'h0111));
    tbl.push_back(mk(0, ACT,  3, 0,  3,  0,  0,  0, 16'h1111));
    tbl.push_back(mk(0, ACT,  0, 1,  3,  4,  1,  1, 16'h1113));
    tbl.push_back(mk(1, NOP,  0, 0,  0,  0,  0,  0, 16'h0000));
    tbl.push_back(mk(0, ACT,  0, 0,  0,  0,  0,  0, 16'h0001));
    tbl.push_back(mk(0, ACT,  1, 0,  3,  0,  0,  0, 16'h0011));
    tbl.push_back(mk(0, ACT,  2, 0,  3,  0,  0,  0, 16'h0111));
    tbl.push_back(mk(0, ACT,  3, 0,  3,  0,  0,  0, 16'h1111));
    tbl.push_back(mk(0, ACT,  0, 1,  7,  0,  0,  0, 16'h1113));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      repeat (tbl[i].w) idle();
      issue(tbl[i].r, tbl[i].v, tbl[i].t, tbl[i].bg, tbl[i].ba);
      chk_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ec,
              tbl[i].eb, tbl[i].ecnt, tbl[i].eopen);
    end

    // A command issued in the reset cycle is neither checked nor tracked.
    issue(1'b1, 1'b1, ACT, 2'd0, 2'd0);
    chk_out("rst_cmd", 1'b0, 4'd0, 4'd0, 16'd0, 16'h0000);
    issue(1'b0, 1'b1, RD, 2'd0, 2'd0);
    chk_out("rst_cmd_rd", 1'b1, 4'd5, 4'd0, 16'd1, 16'h0000);

    // Exact tRCD spacing is legal; a tCCD_L change applies at once.
    issue(1'b0, 1'b1, ACT, 2'd0, 2'd0);
    chk_out("cfg_act", 1'b0, 4'd0, 4'd0, 16'd1, 16'h0001);
    repeat (10) idle();
    issue(1'b0, 1'b1, RD, 2'd0, 2'd0);
    chk_out("trcd_edge", 1'b0, 4'd0, 4'd0, 16'd1, 16'h0001);
    bus.cfg_tccd_l = 8'd20;
    repeat (11) idle();
    issue(1'b0, 1'b1, RD, 2'd0, 2'd0);
    chk_out("tccd_cfg", 1'b1, 4'd7, 4'd0, 16'd2, 16'h0001);
    bus.cfg_tccd_l = 8'd6;
    idle();
    chk_out("pulse_end", 1'b0, 4'd0, 4'd0, 16'd2, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
